// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus responder slice.
// No logic; enum, width codes, address width and an alignment helper.
// Nothing here carries flow control.
package io_bus_pkg;

  localparam int IO_ADDR_W = 40;

  localparam logic [1:0] IO_W_BYTE  = 2'd0;
  localparam logic [1:0] IO_W_SHORT = 2'd1;
  localparam logic [1:0] IO_W_INT   = 2'd2;
  localparam logic [1:0] IO_W_LONG  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } io_resp_state_t;

  // An access is misaligned when its low address bits are not a multiple of its size.
  function automatic logic io_misaligned(input logic [1:0] width, input logic [2:0] off);
    case (width)
      IO_W_SHORT: return off[0];
      IO_W_INT:   return |off[1:0];
      IO_W_LONG:  return |off;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// Master-side task bus: request fields in, read data and status out.
// Combinational bundle, no latency of its own.
// taskValid/taskReady handshake; the responder decides when a task is taken.
interface io_bus_responder_if;
  import io_bus_pkg::*;

  logic [IO_ADDR_W-1:0] address;
  logic                 rwCtrl;
  logic [1:0]           widthCtr;
  logic [63:0]          writeBus;
  logic                 taskValid;
  logic [63:0]          readBus;
  logic                 taskReady;
  logic                 taskError;

  modport master (
    output address, rwCtrl, widthCtr, writeBus, taskValid,
    input  readBus, taskReady, taskError
  );

  modport slave (
    input  address, rwCtrl, widthCtr, writeBus, taskValid,
    output readBus, taskReady, taskError
  );

endinterface

// File: rtl/io_lane_align.sv
// Byte-lane steering between the task bus and the 64-bit doubleword backend.
// Purely combinational, zero latency.
// No handshake; outputs track inputs.
module io_lane_align
  import io_bus_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [2:0]  off,
  input  logic [63:0] wbus,
  input  logic [63:0] mem_rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] rdata
);

  logic [7:0]  be_base;
  logic [63:0] rmask;
  logic [5:0]  sh;

  // Per-width lane pattern and read mask before shifting into position.
  always_comb begin
    be_base = 8'h01;
    rmask   = 64'h0000_0000_0000_00FF;
    case (width)
      IO_W_SHORT: begin be_base = 8'h03; rmask = 64'h0000_0000_0000_FFFF; end
      IO_W_INT:   begin be_base = 8'h0F; rmask = 64'h0000_0000_FFFF_FFFF; end
      IO_W_LONG:  begin be_base = 8'hFF; rmask = 64'hFFFF_FFFF_FFFF_FFFF; end
      default:    ;
    endcase
  end

  assign sh    = {off, 3'b000};
  assign be    = be_base << off;
  assign wdata = wbus << sh;
  // Read data is zero-extended; sign/float handling belongs to the master.
  assign rdata = (mem_rdata >> sh) & rmask;

endmodule

// File: rtl/io_bus_responder.sv
// Turns one task-bus request into one backend doubleword access with timeout.
// Latency: accept at 0, ISSUE from 1, DONE/ERR one cycle after ack or timeout.
// taskReady low while a request is in flight; backend stalls by withholding mem_ack.
module io_bus_responder
  import io_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  io_bus_responder_if.slave   bus,
  output logic                mem_req,
  output logic                mem_we,
  output logic [36:0]         mem_addr,
  output logic [63:0]         mem_wdata,
  output logic [7:0]          mem_be,
  input  logic                mem_ack,
  input  logic [63:0]         mem_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  io_resp_state_t       state;
  logic [IO_ADDR_W-1:0] addr_q;
  logic                 rw_q;
  logic [1:0]           width_q;
  logic [63:0]          wbus_q;
  logic [15:0]          cnt;
  logic                 req_q;
  logic                 err_q;
  logic [63:0]          rdata_q;

  logic [7:0]  lane_be;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;

  io_lane_align u_align (
    .width     (width_q),
    .off       (addr_q[2:0]),
    .wbus      (wbus_q),
    .mem_rdata (mem_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .rdata     (lane_rdata)
  );

  // Request FSM: accept, drive the backend until ack or timeout, report for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      width_q <= IO_W_BYTE;
      wbus_q  <= '0;
      cnt     <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.taskValid) begin
            addr_q  <= bus.address;
            rw_q    <= bus.rwCtrl;
            width_q <= bus.widthCtr;
            // writeBus is tri-stated by the master on reads, so only writes sample it.
            if (bus.rwCtrl) wbus_q <= bus.writeBus;
            cnt <= '0;
            if (io_misaligned(bus.widthCtr, bus.address[2:0])) begin
              state   <= ERR;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state <= ISSUE;
              req_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (mem_ack) begin
            state <= DONE;
            req_q <= 1'b0;
            if (!rw_q) rdata_q <= lane_rdata;
          end else if (cnt == CNT_LAST) begin
            state   <= ERR;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // taskReady is the only combinational output: in IDLE it answers taskValid directly.
  always_comb begin
    bus.taskReady = 1'b0;
    case (state)
      IDLE:     bus.taskReady = !bus.taskValid;
      DONE,
      ERR:      bus.taskReady = 1'b1;
      default:  bus.taskReady = 1'b0;
    endcase
  end

  assign bus.taskError = err_q;
  assign bus.readBus   = rdata_q;

  assign mem_req   = req_q;
  assign mem_we    = rw_q & req_q;
  assign mem_addr  = addr_q[IO_ADDR_W-1:3];
  assign mem_wdata = lane_wdata;
  assign mem_be    = req_q ? lane_be : 8'h00;

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench: directed cases plus randomized requests against a reference model.
// Runs the DUT with a short timeout so both ack and timeout paths are reached.
// Drives and samples on the falling clock edge.
module tb_io_bus_responder;
  import io_bus_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [36:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int checks;
  int errors;
  logic [63:0] model_rb;

  io_bus_responder_if bus_i ();

  io_bus_responder #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_i),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request from an IDLE negedge through DONE/ERR and into the following IDLE cycle.
  // ack_wait = number of ISSUE cycles without ack before acking; negative = never ack.
  task automatic run_txn(input logic [39:0] a, input logic [1:0] w, input logic rw,
                         input logic [63:0] wb, input logic [63:0] rd, input int ack_wait);
    int nbytes, off, exp_cyc, exp_nreq, cyc, nreq, done_cyc;
    bit mis, acked, done, stable, err_early, rec_err;
    logic [63:0] exp_rb, mask, rec_rb, f_wd;
    logic [7:0]  exp_be, f_be;
    logic [36:0] f_addr;
    logic        f_we;

    nbytes = 1 << w;
    off    = int'(a[2:0]);
    mis    = (off % nbytes) != 0;
    acked  = !mis && ack_wait >= 0 && ack_wait < TO;
    mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    exp_be = 8'(((1 << nbytes) - 1) << off);
    if (mis) begin
      exp_cyc = 1; exp_nreq = 0; exp_rb = 64'd0;
    end else if (acked) begin
      exp_cyc  = 2 + ack_wait;
      exp_nreq = ack_wait + 1;
      exp_rb   = rw ? model_rb : ((rd >> (8 * off)) & mask);
    end else begin
      exp_cyc = 1 + TO; exp_nreq = TO; exp_rb = 64'd0;
    end

    check("idle_ready", 64'(bus_i.taskReady), 64'd1);
    bus_i.address   = a;
    bus_i.rwCtrl    = rw;
    bus_i.widthCtr  = w;
    bus_i.writeBus  = rw ? wb : {$urandom, $urandom};
    bus_i.taskValid = 1'b1;
    #1;
    check("accept_ready_low", 64'(bus_i.taskReady), 64'd0);

    cyc = 0; nreq = 0; done = 0; stable = 1; err_early = 0;
    done_cyc = 0; rec_err = 0; rec_rb = '0;
    f_addr = '0; f_be = '0; f_we = 1'b0; f_wd = '0;
    while (!done && cyc < TO + 4) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // Master drops valid and scrambles the bus; the latched request must carry on.
        bus_i.taskValid = 1'b0;
        bus_i.address   = {$urandom, $urandom};
        bus_i.rwCtrl    = 1'($urandom);
        bus_i.widthCtr  = 2'($urandom);
        bus_i.writeBus  = {$urandom, $urandom};
      end
      if (mem_req) begin
        if (nreq == 0) begin
          f_addr = mem_addr; f_be = mem_be; f_we = mem_we; f_wd = mem_wdata;
        end else if (mem_addr !== f_addr || mem_be !== f_be || mem_we !== f_we || mem_wdata !== f_wd) begin
          stable = 0;
        end
        mem_ack   = (ack_wait == nreq);
        mem_rdata = mem_ack ? rd : {$urandom, $urandom};
        nreq++;
      end else begin
        mem_ack = 1'b0;
      end
      if (bus_i.taskReady) begin
        done = 1; done_cyc = cyc; rec_err = bus_i.taskError; rec_rb = bus_i.readBus;
      end else if (bus_i.taskError) begin
        err_early = 1;
      end
    end
    mem_ack = 1'b0;

    check("completed", 64'(done), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(exp_cyc));
    check("task_error", 64'(rec_err), 64'(!acked));
    check("read_bus", rec_rb, exp_rb);
    check("req_cycles", 64'(nreq), 64'(exp_nreq));
    check("error_early", 64'(err_early), 64'd0);
    if (exp_nreq > 0) begin
      check("mem_addr", 64'(f_addr), 64'(a[39:3]));
      check("mem_we", 64'(f_we), 64'(rw));
      check("mem_stable", 64'(stable), 64'd1);
      if (rw) begin
        check("mem_be", 64'(f_be), 64'(exp_be));
        check("mem_wdata", f_wd, wb << (8 * off));
      end
    end
    model_rb = exp_rb;

    @(negedge clk);
    check("rb_hold", bus_i.readBus, model_rb);
    check("err_clear", 64'(bus_i.taskError), 64'd0);
  endtask

  initial begin
    logic [39:0] ra;
    logic [1:0]  rw_w;
    int          aw;
    int          gap;

    checks = 0;
    errors = 0;
    model_rb = '0;
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    bus_i.address = '0;
    bus_i.rwCtrl = 1'b0;
    bus_i.widthCtr = 2'd0;
    bus_i.writeBus = '0;
    bus_i.taskValid = 1'b0;

    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_read_bus", bus_i.readBus, 64'd0);
    check("rst_task_error", 64'(bus_i.taskError), 64'd0);
    check("rst_task_ready", 64'(bus_i.taskReady), 64'd1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Read int at an upper-word address, three wait cycles.
    run_txn(40'h10_0000_0004, IO_W_INT, 1'b0, 64'd0, 64'h89AB_CDEF_0123_4567, 3);
    // Write byte into lane 3.
    run_txn(40'h00_0000_0003, IO_W_BYTE, 1'b1, 64'h0000_0000_0000_00A5, 64'd0, 0);
    // Misaligned short read.
    run_txn(40'h00_0000_0001, IO_W_SHORT, 1'b0, 64'd0, 64'h1111_2222_3333_4444, 0);
    // Timeout with no ack, then ack landing on the last allowed cycle.
    run_txn(40'h00_0000_0040, IO_W_LONG, 1'b0, 64'd0, 64'h5555_6666_7777_8888, -1);
    run_txn(40'h00_0000_0040, IO_W_LONG, 1'b0, 64'd0, 64'h5555_6666_7777_8888, TO - 1);
    // Back-to-back long reads.
    run_txn(40'h00_1234_5678, IO_W_LONG, 1'b0, 64'd0, 64'hFEDC_BA98_7654_3210, 0);
    run_txn(40'h00_1234_5680, IO_W_LONG, 1'b0, 64'd0, 64'h0F1E_2D3C_4B5A_6978, 1);

    // Reset in the middle of ISSUE; a late ack must be ignored.
    bus_i.address = 40'h00_0000_0008;
    bus_i.rwCtrl = 1'b0;
    bus_i.widthCtr = IO_W_LONG;
    bus_i.taskValid = 1'b1;
    @(negedge clk);
    bus_i.taskValid = 1'b0;
    check("issue_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_mem_be", 64'(mem_be), 64'd0);
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_read_bus", bus_i.readBus, 64'd0);
    check("midrst_task_error", 64'(bus_i.taskError), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_read_bus", bus_i.readBus, 64'd0);
    check("late_ack_mem_req", 64'(mem_req), 64'd0);
    check("late_ack_task_error", 64'(bus_i.taskError), 64'd0);
    model_rb = '0;

    // Randomized requests: mostly aligned, random ack delay including timeouts.
    for (int i = 0; i < 40; i++) begin
      rw_w = 2'($urandom_range(0, 3));
      ra = 40'({$urandom, $urandom});
      if ($urandom_range(0, 3) != 0) ra[2:0] = 3'((int'(ra[2:0]) >> rw_w) << rw_w);
      aw = int'($urandom_range(0, 6)) - 1;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_txn(ra, rw_w, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, aw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ISSUE cycles allowed without mem_ack; legal range is 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL connect to IO_Interface.slave: address[39:0], rwCtrl (1 = write), widthCtr[1:0] (0 = byte, 1 = short, 2 = int, 3 = long), writeBus[63:0] and taskValid are inputs; readBus[63:0], taskReady and taskError are outputs.
REQ-005 The block SHALL have backend outputs mem_req (1), mem_we (1), mem_addr[36:0] (doubleword address), mem_wdata[63:0] and mem_be[7:0].
REQ-006 The block SHALL have backend inputs mem_ack (1) and mem_rdata[63:0].

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE, DONE and ERR.
REQ-011 In IDLE, taskReady SHALL equal !taskValid, combinationally.
REQ-012 In ISSUE, taskReady SHALL be 0.
REQ-013 In DONE and ERR, taskReady SHALL be 1 for exactly one cycle.
REQ-014 taskError SHALL be 1 only in ERR.
REQ-015 In IDLE with taskValid=1, the block SHALL latch address, rwCtrl, widthCtr and writeBus (writeBus only if rwCtrl=1).
REQ-016 On that acceptance, the FSM SHALL go to ERR if the request is misaligned, otherwise to ISSUE.
REQ-017 A request SHALL be misaligned when (width 1 and addr[0]!=0), or (width 2 and addr[1:0]!=0), or (width 3 and addr[2:0]!=0).
REQ-018 In ISSUE, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_be SHALL be stable from the latched request.
REQ-019 In ISSUE, mem_ack=1 SHALL capture the read data and move the FSM to DONE; mem_req SHALL be 0 in DONE.
REQ-020 The timeout counter SHALL clear on entry to ISSUE and increment every ISSUE cycle without ack.
REQ-021 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to ERR and mem_req SHALL drop.
REQ-022 If ack arrives on the timeout cycle itself, ack SHALL win and the FSM SHALL go to DONE.
REQ-023 DONE and ERR SHALL return to IDLE unconditionally.
REQ-024 A taskValid=1 seen in the IDLE cycle immediately after DONE/ERR SHALL be accepted as a new request (back-to-back).
REQ-025 Write byte enables: mem_be = (1, 3, 0xF or 0xFF selected by width) << addr[2:0].
REQ-026 Write data: mem_wdata = writeBus << (8*addr[2:0]).
REQ-027 Read data: readBus = (mem_rdata >> (8*addr[2:0])), masked to the width and zero-extended; sign and float conversion are the master's job.
REQ-028 readBus SHALL be registered and valid in DONE, SHALL hold its value until the next DONE, and SHALL be 0 after ERR.
REQ-029 For writes, readBus SHALL be left unchanged.
REQ-030 For reads, writeBus SHALL be ignored, since it is tri-stated by the master.
REQ-031 Minimum latency SHALL be: accept at cycle 0, ISSUE at cycle 1 with ack, DONE/taskReady at cycle 2; each ack wait cycle adds one cycle.
REQ-032 A taskValid deassertion while in ISSUE SHALL NOT abort the transfer; the transaction SHALL complete normally.

Reset
REQ-040 With rst=0, asynchronously: state = IDLE, mem_req = 0, mem_we = 0, mem_be = 0, readBus = 0, taskError = 0, counter = 0, latched fields = 0.
REQ-041 After reset, taskReady SHALL follow REQ-011, i.e. it is 1 when taskValid=0.
REQ-042 Reset asserted mid-ISSUE SHALL drop mem_req immediately; any later mem_ack SHALL be ignored in IDLE.

Structure
REQ-050 Shared package io_bus_pkg SHALL hold the state enum io_resp_state_t, the width codes IO_W_BYTE, IO_W_SHORT, IO_W_INT and IO_W_LONG, and IO_ADDR_W = 40.
REQ-051 Sub-module io_lane_align SHALL be purely combinational and produce be, wdata and rdata from width, addr[2:0], writeBus and mem_rdata.
REQ-052 The FSM, counter and registers SHALL live in io_bus_responder.

Verification
REQ-060 Read int at addr 0x10_0000_0004 with mem_rdata=0x89ABCDEF_01234567 and ack after 3 cycles -> mem_addr=0x2_0000_0000, readBus=0x0000_0000_89AB_CDEF, taskReady pulse at cycle 5, taskError=0.
REQ-061 Write byte 0xA5 at addr 0x3 -> mem_be=0x08, mem_wdata[31:24]=0xA5, mem_we=1, then DONE.
REQ-062 Read short at odd addr 0x1 -> ERR in cycle 1, taskReady=taskError=1 for one cycle, mem_req never asserted.
REQ-063 TIMEOUT=4, mem_ack never asserted -> mem_req high for exactly 4 cycles, then ERR; ack on the 4th cycle instead -> DONE.
REQ-064 Two back-to-back long reads -> second accepted in the IDLE cycle after the first DONE, both readBus values correct.
REQ-065 rst pulsed low during ISSUE -> outputs at reset values immediately; a late mem_ack does not produce taskReady or a data update.
